// File: rtl/clk_lock_monitor.sv
// Per-channel PLL lock supervisor: synchronises each lock input, qualifies it, holds the
// PLL in reset after a loss of lock, counts losses and drives a status LED from a shared blink timebase.
module clk_lock_monitor #(
  parameter int CHANNELS       = 2,
  parameter int QUAL_CYCLES    = 1000000,
  parameter int HOLDOFF_CYCLES = 100000,
  parameter int BLINK_DIV      = 12500000,
  parameter int CNT_W          = 8
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       locked,
  input  logic                      clear_counts,
  output logic [CHANNELS-1:0]       link_up,
  output logic                      all_up,
  output logic [CHANNELS-1:0]       pll_reset_n,
  output logic [CHANNELS*CNT_W-1:0] loss_count,
  output logic [CHANNELS-1:0]       led
);

  localparam int MAX_C = (QUAL_CYCLES > HOLDOFF_CYCLES) ? QUAL_CYCLES : HOLDOFF_CYCLES;
  localparam int CW    = (MAX_C > 2) ? $clog2(MAX_C) : 1;
  localparam int PW    = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CW-1:0]    QUAL_LAST = CW'(QUAL_CYCLES - 1);
  localparam logic [CW-1:0]    HOLD_LAST = CW'(HOLDOFF_CYCLES - 1);
  localparam logic [CW-1:0]    CNT_ZERO  = {CW{1'b0}};
  localparam logic [PW-1:0]    PRE_LAST  = PW'(BLINK_DIV - 1);
  localparam logic [CNT_W-1:0] LOSS_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LOSS_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] LOSS_ONE  = CNT_W'(1'b1);

  typedef enum logic [1:0] {
    ST_DOWN = 2'd0,
    ST_QUAL = 2'd1,
    ST_UP   = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t              r_state     [CHANNELS];
  state_t              w_state_nxt [CHANNELS];
  logic [CW-1:0]       r_cnt       [CHANNELS];
  logic [CW-1:0]       w_cnt_nxt   [CHANNELS];
  logic [CNT_W-1:0]    r_loss      [CHANNELS];
  logic [CNT_W-1:0]    w_loss_nxt  [CHANNELS];

  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;
  logic [CHANNELS-1:0] r_link_up;
  logic [CHANNELS-1:0] r_pll_rst_n;
  logic [CHANNELS-1:0] r_led;
  logic                r_all_up;
  logic [CHANNELS-1:0] w_up_nxt;
  logic [CHANNELS-1:0] w_rst_n_nxt;
  logic [CHANNELS-1:0] w_led_nxt;

  logic [PW-1:0]       r_pre;
  logic [2:0]          r_b;
  logic [PW-1:0]       w_pre_nxt;
  logic [2:0]          w_b_nxt;
  logic                w_fast;
  logic                w_slow;

  // Two-flop synchroniser per lock input.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_sync1 <= {CHANNELS{1'b0}};
      r_sync2 <= {CHANNELS{1'b0}};
    end else begin
      r_sync1 <= locked;
      r_sync2 <= r_sync1;
    end
  end

  // Shared blink timebase: prescaler wrap advances the 3-bit tick counter.
  always_comb begin
    w_pre_nxt = r_pre + PW'(1'b1);
    w_b_nxt   = r_b;
    if (r_pre == PRE_LAST) begin
      w_pre_nxt = {PW{1'b0}};
      w_b_nxt   = r_b + 3'd1;
    end else begin
      w_b_nxt   = r_b;
    end
    w_fast = w_b_nxt[0];
    w_slow = w_b_nxt[2];
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_pre <= {PW{1'b0}};
      r_b   <= 3'd0;
    end else begin
      r_pre <= w_pre_nxt;
      r_b   <= w_b_nxt;
    end
  end

  // State register: channel FSMs, their shared qualify/holdoff counter and loss counters.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_state[i] <= ST_DOWN;
        r_cnt[i]   <= CNT_ZERO;
        r_loss[i]  <= LOSS_ZERO;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
        r_loss[i]  <= w_loss_nxt[i];
      end
    end
  end

  // Next-state logic; a clear coinciding with a loss leaves the count at one.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      w_loss_nxt[i]  = clear_counts ? LOSS_ZERO : r_loss[i];
      case (r_state[i])
        ST_DOWN: begin
          if (r_sync2[i]) begin
            w_state_nxt[i] = ST_QUAL;
            w_cnt_nxt[i]   = CNT_ZERO;
          end else begin
            w_state_nxt[i] = ST_DOWN;
          end
        end
        ST_QUAL: begin
          if (!r_sync2[i]) begin
            w_state_nxt[i] = ST_DOWN;
            w_cnt_nxt[i]   = CNT_ZERO;
          end else if (r_cnt[i] == QUAL_LAST) begin
            w_state_nxt[i] = ST_UP;
            w_cnt_nxt[i]   = CNT_ZERO;
          end else begin
            w_cnt_nxt[i]   = r_cnt[i] + CW'(1'b1);
          end
        end
        ST_UP: begin
          if (!r_sync2[i]) begin
            w_state_nxt[i] = ST_HOLD;
            w_cnt_nxt[i]   = CNT_ZERO;
            if (clear_counts) begin
              w_loss_nxt[i] = LOSS_ONE;
            end else if (r_loss[i] == LOSS_MAX) begin
              w_loss_nxt[i] = r_loss[i];
            end else begin
              w_loss_nxt[i] = r_loss[i] + LOSS_ONE;
            end
          end else begin
            w_state_nxt[i] = ST_UP;
          end
        end
        ST_HOLD: begin
          if (r_cnt[i] == HOLD_LAST) begin
            w_state_nxt[i] = ST_DOWN;
            w_cnt_nxt[i]   = CNT_ZERO;
          end else begin
            w_cnt_nxt[i]   = r_cnt[i] + CW'(1'b1);
          end
        end
        default: begin
          w_state_nxt[i] = ST_DOWN;
          w_cnt_nxt[i]   = CNT_ZERO;
        end
      endcase
    end
  end

  // Output decode from the next state so the registered outputs track the state register.
  always_comb begin
    w_up_nxt    = {CHANNELS{1'b0}};
    w_rst_n_nxt = {CHANNELS{1'b1}};
    w_led_nxt   = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      case (w_state_nxt[i])
        ST_DOWN: begin
          w_led_nxt[i] = 1'b0;
        end
        ST_QUAL: begin
          w_led_nxt[i] = w_slow;
        end
        ST_UP: begin
          w_up_nxt[i]  = 1'b1;
          w_led_nxt[i] = 1'b1;
        end
        ST_HOLD: begin
          w_rst_n_nxt[i] = 1'b0;
          w_led_nxt[i]   = w_fast;
        end
        default: begin
          w_led_nxt[i] = 1'b0;
        end
      endcase
    end
  end

  // Registered status outputs.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_link_up   <= {CHANNELS{1'b0}};
      r_all_up    <= 1'b0;
      r_pll_rst_n <= {CHANNELS{1'b1}};
      r_led       <= {CHANNELS{1'b0}};
    end else begin
      r_link_up   <= w_up_nxt;
      r_all_up    <= &w_up_nxt;
      r_pll_rst_n <= w_rst_n_nxt;
      r_led       <= w_led_nxt;
    end
  end

  always_comb begin
    loss_count = {(CHANNELS*CNT_W){1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      loss_count[i*CNT_W +: CNT_W] = r_loss[i];
    end
  end

  assign link_up     = r_link_up;
  assign all_up      = r_all_up;
  assign pll_reset_n = r_pll_rst_n;
  assign led         = r_led;

endmodule

// File: tb/tb_clk_lock_monitor.sv
// Scoreboard bench for clk_lock_monitor: a driver feeds lock patterns and pushes the
// reference model's expected outputs; a monitor pops and compares one entry per clock edge.
module tb_clk_lock_monitor;

  localparam int CH   = 2;
  localparam int QC   = 16;
  localparam int HC   = 8;
  localparam int DIV  = 4;
  localparam int CW   = 2;
  localparam int LMAX = (1 << CW) - 1;

  localparam int P_DOWN = 0;
  localparam int P_QUAL = 1;
  localparam int P_UP   = 2;
  localparam int P_HOLD = 3;

  logic              clk_in = 1'b0;
  logic              reset = 1'b1;
  logic [CH-1:0]     locked = '0;
  logic              clear_counts = 1'b0;
  logic [CH-1:0]     link_up;
  logic              all_up;
  logic [CH-1:0]     pll_reset_n;
  logic [CH*CW-1:0]  loss_count;
  logic [CH-1:0]     led;

  clk_lock_monitor #(
    .CHANNELS(CH), .QUAL_CYCLES(QC), .HOLDOFF_CYCLES(HC), .BLINK_DIV(DIV), .CNT_W(CW)
  ) dut (
    .clk_in(clk_in), .reset(reset), .locked(locked), .clear_counts(clear_counts),
    .link_up(link_up), .all_up(all_up), .pll_reset_n(pll_reset_n),
    .loss_count(loss_count), .led(led)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [CH-1:0]    link;
    logic             all;
    logic [CH-1:0]    pll;
    logic [CH*CW-1:0] loss;
    logic [CH-1:0]    led;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model: lock seen through a two-sample delay, a streak of good samples
  // qualifies, a fixed-length countdown releases the PLL, blink phase is edges/DIV.
  int   m_phase [CH];
  int   m_streak[CH];
  int   m_left  [CH];
  int   m_loss  [CH];
  logic m_hist  [CH][$];
  int   m_edges;

  task automatic model_edge(input logic [CH-1:0] lk, input logic clr, input logic rst);
    exp_t e;
    int   b;
    logic ls;
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        m_phase[i] = P_DOWN; m_streak[i] = 0; m_left[i] = 0; m_loss[i] = 0;
        m_hist[i] = {1'b0, 1'b0};
      end
      m_edges = 0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        ls = m_hist[i].pop_front();
        m_hist[i].push_back(lk[i]);
        if (clr) m_loss[i] = 0;
        if (m_phase[i] == P_DOWN || m_phase[i] == P_QUAL) begin
          m_streak[i] = ls ? m_streak[i] + 1 : 0;
          if (m_streak[i] == 0) m_phase[i] = P_DOWN;
          else if (m_streak[i] == QC + 1) m_phase[i] = P_UP;
          else m_phase[i] = P_QUAL;
        end else if (m_phase[i] == P_UP) begin
          if (!ls) begin
            m_phase[i] = P_HOLD;
            m_left[i]  = HC;
            m_loss[i]  = clr ? 1 : ((m_loss[i] + 1 > LMAX) ? LMAX : m_loss[i] + 1);
          end
        end else begin
          m_left[i] = m_left[i] - 1;
          if (m_left[i] == 0) begin
            m_phase[i]  = P_DOWN;
            m_streak[i] = 0;
          end
        end
      end
      m_edges++;
    end
    b = (m_edges / DIV) % 8;
    e.all = 1'b1;
    for (int i = 0; i < CH; i++) begin
      e.link[i] = (m_phase[i] == P_UP);
      e.pll[i]  = (m_phase[i] != P_HOLD);
      e.all     = e.all & e.link[i];
      e.loss[i*CW +: CW] = CW'(m_loss[i]);
      case (m_phase[i])
        P_QUAL:  e.led[i] = b[2];
        P_UP:    e.led[i] = 1'b1;
        P_HOLD:  e.led[i] = b[0];
        default: e.led[i] = 1'b0;
      endcase
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [CH-1:0] lk, input logic clr, input logic rst);
    @(negedge clk_in);
    locked = lk; clear_counts = clr; reset = rst;
    model_edge(lk, clr, rst);
  endtask

  task automatic hold(input logic [CH-1:0] lk, input int n);
    for (int k = 0; k < n; k++) step(lk, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
  endtask

  // Monitor: every edge the DUT presents a new output set; compare it with the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("link_up",     32'(link_up),     32'(e.link));
        chk("all_up",      32'(all_up),      32'(e.all));
        chk("pll_reset_n", 32'(pll_reset_n), 32'(e.pll));
        chk("loss_count",  32'(loss_count),  32'(e.loss));
        chk("led",         32'(led),         32'(e.led));
      end
    end
  end

  initial begin
    logic [CH-1:0] rl;
    int            dur;
    int            wait_cnt;
    for (int i = 0; i < CH; i++) m_hist[i] = {1'b0, 1'b0};
    m_edges = 0;

    for (int k = 0; k < 3; k++) step(2'b00, 1'b0, 1'b1);
    // Channel 0 qualifies alone.
    hold(2'b01, 30);
    // One-cycle dropout: holdoff, loss count, then re-qualify.
    hold(2'b00, 1);
    hold(2'b01, 40);
    // Channel 1 aborts qualification.
    hold(2'b11, 10);
    hold(2'b01, 10);
    // Five loss cycles on channel 1 to reach saturation.
    for (int r = 0; r < 5; r++) begin
      hold(2'b11, 22);
      hold(2'b01, 12);
    end
    step(2'b01, 1'b1, 1'b0);
    hold(2'b11, 22);
    // Clear lands on the same edge as channel 1's loss increment.
    step(2'b01, 1'b0, 1'b0);
    step(2'b01, 1'b0, 1'b0);
    step(2'b01, 1'b1, 1'b0);
    hold(2'b11, 30);
    // Both up, then reset in the middle of channel 0's holdoff.
    hold(2'b10, 1);
    hold(2'b11, 5);
    step(2'b11, 1'b0, 1'b1);
    hold(2'b11, 25);

    for (int seg = 0; seg < 40; seg++) begin
      rl  = CH'($urandom_range(0, 3));
      dur = $urandom_range(1, 30);
      for (int k = 0; k < dur; k++)
        step(rl, ($urandom_range(0, 15) == 0), ($urandom_range(0, 299) == 0));
    end

    @(negedge clk_in);
    clear_counts = 1'b0;
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(negedge clk_in);
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
